// File: rtl/bus_fill_arbiter_pkg.sv
// Shared constants, state type and tag helper for the cache-line fill arbiter.
package bus_pkg;

   localparam logic        TAG_READ         = 1'b1;
   localparam logic        TAG_WRITE        = 1'b0;
   localparam logic [3:0]  TAG_MEMORY       = 4'b0001;
   localparam int unsigned LINE_BEATS       = 8;
   localparam int unsigned LINE_OFFSET_BITS = 6;
   localparam int unsigned FILL_TAG_WIDTH   = 13;

   typedef enum logic [1:0] {IDLE, REQ, RESP} fill_state_t;

   // Read-from-memory tag; the grant id in bit 0 routes the response.
   function automatic logic [FILL_TAG_WIDTH-1:0] fill_tag(input logic gid);
      return {TAG_READ, TAG_MEMORY, 7'b0, gid};
   endfunction

endpackage

// File: rtl/bus_fill_arbiter_if.sv
// Requester-side and system-bus-side signals of the fill arbiter.
interface bus_fill_arbiter_if #(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13,
   parameter int unsigned ADDR_WIDTH     = 64
);

   logic [1:0]                 req_valid;
   logic [1:0][ADDR_WIDTH-1:0] req_addr;
   logic [1:0]                 req_ready;
   logic [1:0]                 resp_valid;
   logic [BUS_DATA_WIDTH-1:0]  resp_data;
   logic [2:0]                 resp_beat;
   logic                       resp_last;
   logic                       tag_err;

   logic                       bus_reqcyc;
   logic                       bus_respack;
   logic [BUS_DATA_WIDTH-1:0]  bus_req;
   logic [BUS_TAG_WIDTH-1:0]   bus_reqtag;
   logic                       bus_respcyc;
   logic                       bus_reqack;
   logic [BUS_DATA_WIDTH-1:0]  bus_resp;
   logic [BUS_TAG_WIDTH-1:0]   bus_resptag;

   modport master (
      input  req_valid, req_addr, bus_respcyc, bus_reqack, bus_resp, bus_resptag,
      output req_ready, resp_valid, resp_data, resp_beat, resp_last, tag_err,
             bus_reqcyc, bus_respack, bus_req, bus_reqtag
   );

   modport slave (
      output req_valid, req_addr, bus_respcyc, bus_reqack, bus_resp, bus_resptag,
      input  req_ready, resp_valid, resp_data, resp_beat, resp_last, tag_err,
             bus_reqcyc, bus_respack, bus_req, bus_reqtag
   );

endinterface

// File: rtl/bus_fill_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a tie goes to the port that did not win last time.
module rr_arbiter2 (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic       gnt_o,
   output logic       any_o
);

   always_comb begin
      any_o = |valid_i;
      unique case (valid_i)
         2'b01:   gnt_o = 1'b0;
         2'b10:   gnt_o = 1'b1;
         2'b11:   gnt_o = ~last_grant_i;
         default: gnt_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/bus_fill_arbiter.sv
// Arbitrates I-cache and D-cache line fills onto one system bus port, one read
// at a time, and streams the 8-beat response back to the granted requester.
module bus_fill_arbiter #(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13,
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned LINE_BEATS     = 8
) (
   input logic                clk,
   input logic                reset,
   bus_fill_arbiter_if.master fill_io
);

   import bus_pkg::*;

   localparam logic [2:0] LastBeat = 3'(LINE_BEATS - 1);

   fill_state_t               state_q, state_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic                      gid_q, gid_d;
   logic                      last_grant_q, last_grant_d;
   logic [2:0]                beat_q, beat_d;
   logic [1:0]                resp_valid_q, resp_valid_d;
   logic [BUS_DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic [2:0]                resp_beat_q, resp_beat_d;
   logic                      resp_last_q, resp_last_d;
   logic                      tag_err_q, tag_err_d;

   logic                      arb_gnt, arb_any;
   logic [BUS_TAG_WIDTH-1:0]  cur_tag;
   logic                      beat_in, beat_hit;

   rr_arbiter2 u_arb (
      .valid_i      (fill_io.req_valid),
      .last_grant_i (last_grant_q),
      .gnt_o        (arb_gnt),
      .any_o        (arb_any)
   );

   assign cur_tag  = BUS_TAG_WIDTH'(fill_tag(gid_q));
   assign beat_in  = (state_q == RESP) && fill_io.bus_respcyc;
   assign beat_hit = beat_in && (fill_io.bus_resptag == cur_tag);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      gid_d        = gid_q;
      last_grant_d = last_grant_q;
      beat_d       = beat_q;
      resp_valid_d = 2'b00;
      resp_data_d  = resp_data_q;
      resp_beat_d  = resp_beat_q;
      resp_last_d  = 1'b0;
      tag_err_d    = tag_err_q;
      unique case (state_q)
         IDLE: begin
            if (arb_any) begin
               addr_d  = {fill_io.req_addr[arb_gnt][ADDR_WIDTH-1:LINE_OFFSET_BITS],
                          LINE_OFFSET_BITS'(0)};
               gid_d   = arb_gnt;
               state_d = REQ;
            end
         end
         REQ: begin
            if (fill_io.bus_reqack) state_d = RESP;
         end
         RESP: begin
            if (beat_hit) begin
               resp_valid_d = gid_q ? 2'b10 : 2'b01;
               resp_data_d  = fill_io.bus_resp;
               resp_beat_d  = beat_q;
               resp_last_d  = (beat_q == LastBeat);
               if (beat_q == LastBeat) begin
                  beat_d       = 3'd0;
                  last_grant_d = gid_q;
                  state_d      = IDLE;
               end else begin
                  beat_d = beat_q + 3'd1;
               end
            end else if (beat_in) begin
               // Foreign tag: acked so the bus can move on, but the data is dropped.
               tag_err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         gid_q        <= 1'b0;
         last_grant_q <= 1'b1;
         beat_q       <= 3'd0;
         resp_valid_q <= 2'b00;
         resp_data_q  <= '0;
         resp_beat_q  <= 3'd0;
         resp_last_q  <= 1'b0;
         tag_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         gid_q        <= gid_d;
         last_grant_q <= last_grant_d;
         beat_q       <= beat_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_beat_q  <= resp_beat_d;
         resp_last_q  <= resp_last_d;
         tag_err_q    <= tag_err_d;
      end
   end

   // req_ready is combinational, so it is also forced low while reset is held.
   assign fill_io.req_ready   = (state_q == IDLE && arb_any && !reset) ?
                                (arb_gnt ? 2'b10 : 2'b01) : 2'b00;
   assign fill_io.bus_reqcyc  = (state_q == REQ);
   assign fill_io.bus_req     = (state_q == REQ) ? BUS_DATA_WIDTH'(addr_q) : '0;
   assign fill_io.bus_reqtag  = (state_q == REQ) ? cur_tag : '0;
   assign fill_io.bus_respack = beat_in;
   assign fill_io.resp_valid  = resp_valid_q;
   assign fill_io.resp_data   = resp_data_q;
   assign fill_io.resp_beat   = resp_beat_q;
   assign fill_io.resp_last   = resp_last_q;
   assign fill_io.tag_err     = tag_err_q;

endmodule

// File: tb/tb_bus_fill_arbiter.sv
// Directed bench for bus_fill_arbiter: fills, arbitration, wrong tags, reset.
module tb_bus_fill_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bus_fill_arbiter_if fill_if ();

   bus_fill_arbiter dut (
      .clk     (clk),
      .reset   (reset),
      .fill_io (fill_if)
   );

   int total = 0;
   int bad   = 0;

   logic [1:0]  exp_rv;
   logic [63:0] exp_data;
   logic [2:0]  exp_beat;
   logic        exp_last;
   int          tb_cnt;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   // Registered response outputs reflect the beat accepted in the previous cycle.
   task automatic chk_out(input string tag);
      check({tag, ".resp_valid"}, fill_if.resp_valid, exp_rv);
      check({tag, ".resp_last"}, fill_if.resp_last, exp_last);
      if (exp_rv != 2'b00) begin
         check({tag, ".resp_data"}, fill_if.resp_data, exp_data);
         check({tag, ".resp_beat"}, fill_if.resp_beat, exp_beat);
      end
      exp_rv   = 2'b00;
      exp_last = 1'b0;
   endtask

   task automatic do_req(input logic [1:0] v, input logic [1:0] exp_ready, input string tag);
      chk_out(tag);
      fill_if.req_valid = v;
      settle();
      check({tag, ".req_ready"}, fill_if.req_ready, exp_ready);
      check({tag, ".reqcyc_idle"}, fill_if.bus_reqcyc, 0);
      step();
      fill_if.req_valid = v & ~exp_ready;
      tb_cnt = 0;
   endtask

   // n cycles in REQ, reqack on the last; a correctly tagged stray beat on the
   // first cycle must not be acked.
   task automatic req_phase(input logic [63:0] a, input logic [12:0] t, input int n,
                            input string tag);
      for (int i = 0; i < n; i++) begin
         chk_out(tag);
         fill_if.bus_reqack  = (i == n - 1);
         fill_if.bus_respcyc = (i == 0);
         fill_if.bus_resptag = t;
         settle();
         check({tag, ".reqcyc"}, fill_if.bus_reqcyc, 1);
         check({tag, ".bus_req"}, fill_if.bus_req, a);
         check({tag, ".reqtag"}, fill_if.bus_reqtag, t);
         check({tag, ".respack_in_req"}, fill_if.bus_respack, 0);
         step();
      end
      fill_if.bus_reqack  = 1'b0;
      fill_if.bus_respcyc = 1'b0;
   endtask

   task automatic beat(input logic cyc, input logic good, input logic [63:0] d,
                       input logic [12:0] t, input logic [1:0] port_oh, input string tag);
      chk_out(tag);
      fill_if.bus_respcyc = cyc;
      fill_if.bus_resp    = d;
      fill_if.bus_resptag = t;
      settle();
      check({tag, ".respack"}, fill_if.bus_respack, cyc);
      check({tag, ".reqcyc_resp"}, fill_if.bus_reqcyc, 0);
      check({tag, ".ready_busy"}, fill_if.req_ready, 0);
      if (cyc && good) begin
         exp_rv   = port_oh;
         exp_data = d;
         exp_beat = 3'(tb_cnt);
         exp_last = (tb_cnt == 7);
         tb_cnt++;
      end
      step();
      fill_if.bus_respcyc = 1'b0;
   endtask

   task automatic fill(input logic [1:0] port_oh, input logic [63:0] base,
                       input logic [12:0] t, input string tag);
      for (int i = 0; i < 8; i++) beat(1'b1, 1'b1, base + 64'(i), t, port_oh, tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset    = 1'b0;
      exp_rv   = 2'b00;
      exp_last = 1'b0;
      tb_cnt   = 0;
   endtask

   initial begin
      fill_if.req_valid   = 2'b00;
      fill_if.req_addr    = '0;
      fill_if.bus_respcyc = 1'b0;
      fill_if.bus_reqack  = 1'b0;
      fill_if.bus_resp    = '0;
      fill_if.bus_resptag = '0;
      exp_rv   = 2'b00;
      exp_data = '0;
      exp_beat = 3'd0;
      exp_last = 1'b0;
      tb_cnt   = 0;

      #2;
      check("rst.resp_valid", fill_if.resp_valid, 0);
      check("rst.reqcyc", fill_if.bus_reqcyc, 0);
      check("rst.respack", fill_if.bus_respack, 0);
      check("rst.tag_err", fill_if.tag_err, 0);
      check("rst.req_ready", fill_if.req_ready, 0);
      do_reset();

      // Single I-fetch with reqack after three REQ cycles.
      fill_if.req_addr[0] = 64'h1_0047;
      do_req(2'b01, 2'b01, "t1.req");
      req_phase(64'h1_0040, 13'h1100, 3, "t1.reqph");
      fill(2'b01, 64'hA0, 13'h1100, "t1.fill");

      // Simultaneous requests starting from reset: 0, then 1, then 0 again.
      do_reset();
      fill_if.req_addr[0] = 64'h2_0080;
      fill_if.req_addr[1] = 64'h3_00C5;
      do_req(2'b11, 2'b01, "t2.both0");
      req_phase(64'h2_0080, 13'h1100, 1, "t2.reqph0");
      fill(2'b01, 64'hB0, 13'h1100, "t2.fill0");
      do_req(2'b10, 2'b10, "t2.req1");
      req_phase(64'h3_00C0, 13'h1101, 1, "t2.reqph1");
      fill(2'b10, 64'hC0, 13'h1101, "t2.fill1");
      do_req(2'b11, 2'b01, "t2.both1");

      // Wrong-tag beat inside the port-0 fill; port 1 stays pending throughout.
      req_phase(64'h2_0080, 13'h1100, 2, "t3.reqph");
      beat(1'b1, 1'b1, 64'hD0, 13'h1100, 2'b01, "t3.b0");
      beat(1'b1, 1'b0, 64'hEE, 13'h1101, 2'b01, "t3.bad");
      check("t3.tag_err", fill_if.tag_err, 1);
      for (int i = 1; i < 8; i++) beat(1'b1, 1'b1, 64'hD0 + 64'(i), 13'h1100, 2'b01, "t3.fill");

      // Back-to-back: port 1 taken in the first IDLE cycle, bursty response.
      do_req(2'b10, 2'b10, "t4.req");
      req_phase(64'h3_00C0, 13'h1101, 1, "t4.reqph");
      begin
         int k;
         k = 0;
         for (int i = 0; i < 22; i++) begin
            if (i % 3 == 0) begin
               beat(1'b1, 1'b1, 64'hE0 + 64'(k), 13'h1101, 2'b10, "t4.burst");
               k++;
            end else begin
               beat(1'b0, 1'b0, 64'hFF, 13'h1101, 2'b10, "t4.gap");
            end
         end
      end
      check("t4.tag_err_sticky", fill_if.tag_err, 1);

      // Reset while beat 4 is on the bus.
      fill_if.req_addr[0] = 64'h4_0107;
      do_req(2'b01, 2'b01, "t5.req");
      req_phase(64'h4_0100, 13'h1100, 1, "t5.reqph");
      for (int i = 0; i < 4; i++) beat(1'b1, 1'b1, 64'hF0 + 64'(i), 13'h1100, 2'b01, "t5.fill");
      chk_out("t5.pre");
      fill_if.req_valid   = 2'b01;
      fill_if.bus_respcyc = 1'b1;
      fill_if.bus_resp    = 64'hF4;
      fill_if.bus_resptag = 13'h1100;
      reset = 1'b1;
      #1;
      check("t5.rst.resp_valid", fill_if.resp_valid, 0);
      check("t5.rst.respack", fill_if.bus_respack, 0);
      check("t5.rst.tag_err", fill_if.tag_err, 0);
      check("t5.rst.req_ready", fill_if.req_ready, 0);
      check("t5.rst.reqcyc", fill_if.bus_reqcyc, 0);
      check("t5.rst.resp_data", fill_if.resp_data, 0);
      check("t5.rst.resp_beat", fill_if.resp_beat, 0);
      fill_if.bus_respcyc = 1'b0;
      step();
      do_reset();
      fill_if.req_addr[0] = 64'h5_0001;
      do_req(2'b01, 2'b01, "t5.req2");
      req_phase(64'h5_0000, 13'h1100, 1, "t5.reqph2");
      fill(2'b01, 64'h10, 13'h1100, "t5.fill2");
      chk_out("t5.end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bus_fill_arbiter.md
Name: bus_fill_arbiter

Overview:
- Sits between the Core's fetch and data-cache fill logic and the single system bus port that the top level exports.
- Accepts cache-line read requests from two requesters: port 0 is the I-cache and port 1 is the D-cache.
- Arbitrates between them round-robin and issues one bus read at a time.
- Collects the 8-beat line response and streams each beat back to the granted requester.

Parameters:
- BUS_DATA_WIDTH, 64, bus data width and beat width.
- BUS_TAG_WIDTH, 13, bus tag width.
- ADDR_WIDTH, 64, request address width.
- LINE_BEATS, 8, beats per cache line (64 B line).

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-port line-read request; held high until req_ready.
- req_addr  in  2 x ADDR_WIDTH  per-port byte address; low 6 bits are ignored.
- req_ready  out  2  one-hot; high for one cycle on the cycle a request is accepted.
- resp_valid  out  2  one-hot; registered response beat valid for the granted port.
- resp_data  out  BUS_DATA_WIDTH  response beat data, shared by both ports.
- resp_beat  out  3  beat index, 0..LINE_BEATS-1.
- resp_last  out  1  high with the final beat.
- tag_err  out  1  sticky; set when a response beat arrives with a mismatched tag.
- bus_reqcyc  out  1  bus request valid.
- bus_respack  out  1  acknowledge for a response beat.
- bus_req  out  BUS_DATA_WIDTH  request address, line-aligned.
- bus_reqtag  out  BUS_TAG_WIDTH  request tag.
- bus_respcyc  in  1  response beat valid.
- bus_reqack  in  1  bus has accepted the request.
- bus_resp  in  BUS_DATA_WIDTH  response beat data.
- bus_resptag  in  BUS_TAG_WIDTH  response tag.

Behaviour:
- Reset (asynchronous): state=IDLE, last_grant=1 so port 0 wins the first tie. All outputs 0, including tag_err.
- Reset mid-transaction abandons the transfer. The bus is reset by the same signal.
- Tag format, decided for this block: bit 12=1 (READ), bits 11:8=4'b0001 (MEMORY), bits 7:1=0, bit 0=grant id.
- IDLE state:
  - If no req_valid is high, stay in IDLE.
  - Select a grant g: if exactly one port is valid, grant it; if both are valid, grant the port that is not last_grant.
  - Assert req_ready[g] combinationally in the same cycle.
  - Latch {req_addr[g][63:6], 6'b0} and g.
  - Next state: REQ.
- REQ state:
  - Drive bus_reqcyc=1, bus_req=latched address, bus_reqtag=tag(g).
  - Hold these values stable until bus_reqack is sampled high.
  - On reqack: next state RESP; bus_reqcyc drops to 0 from the next cycle.
  - bus_respcyc seen in REQ is ignored and not acked.
- RESP state:
  - When bus_respcyc=1 and bus_resptag==tag(g): bus_respack=1 combinationally in the same cycle.
  - Capture bus_resp into resp_data and set resp_valid[g]=1 and resp_beat=beat_cnt on the next edge (1-cycle latency).
  - Then increment beat_cnt.
  - When bus_respcyc=1 and the tag mismatches: still ack, drop the data, set tag_err, do not advance beat_cnt.
  - After accepting beat LINE_BEATS-1: resp_last=1 with that registered beat; last_grant<=g; beat_cnt<=0; next state IDLE.
- No bus_respcyc in RESP: stay in RESP, resp_valid=0. There is no timeout.
- Minimum request-to-request gap: a request pending during the last RESP cycle is accepted in the following IDLE cycle.
- Requester contract: req_valid and req_addr stay stable until req_ready. Dropping req_valid before ready withdraws the request. Only one request per port is outstanding.
- Latency: req_valid at cycle 0 gives req_ready at cycle 0 and bus_reqcyc at cycle 1. With reqack at cycle 1, the first beat accepted at cycle 2 appears as resp_valid at cycle 3.
- beat_cnt is 3 bits and never wraps within a line; it is cleared at end of line.

Decomposition:
- Package bus_pkg holds:
  - tag field constants: TAG_READ, TAG_WRITE, TAG_MEMORY;
  - LINE_BEATS and LINE_OFFSET_BITS=6;
  - state enum fill_state_t {IDLE, REQ, RESP}.
- One sub-module, rr_arbiter2: 2-way round-robin grant from the valid bits and last_grant, combinational.

Test Plan:
- Single I-fetch: req_valid=2'b01, addr=0x1_0047, reqack after 3 cycles, 8 beats 0xA0..0xA7 -> bus_req=0x1_0040 and tag=0x1100, held 3 cycles; port 0 receives beats 0..7 in order; resp_last on 0xA7; port 1 sees no resp_valid.
- Simultaneous requests: both valid at reset -> port 0 granted first (tag 0x1100), then port 1 (tag 0x1101); repeat both -> port 0 again.
- Bursty response: bus_respcyc toggled 1,0,0,1,... -> respack only on respcyc cycles; beats contiguous in index; no duplicate or lost beats.
- Wrong tag: inject beat with tag 0x1101 during a port-0 fill -> acked, not forwarded, tag_err=1; the fill still completes after 8 correct beats.
- Reset at beat 4: assert reset mid-RESP -> all outputs 0 immediately; the next request after release is issued cleanly with beat index starting at 0.
- Back-to-back: port 1 requests during the last beat of a port-0 fill -> req_ready[1] in the first IDLE cycle; bus_reqcyc the cycle after.
